// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy; read data is the head entry.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      push,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                      overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  wr_ok, rd_ok;

  // Full is judged on the current count, so a pop cannot rescue a write.
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = push && !full;
  assign rd_ok   = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      overflow <= push && full;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: runtime divisor, optional parity, 1/2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic                              wr_en,
  input  logic                              tx_enable,
  input  logic [DIV_WIDTH-1:0]              baud_div,
  input  logic [1:0]                        parity_mode,
  input  logic                              two_stop,
  output logic                              tx,
  output logic                              tx_done,
  output logic                              busy,
  output logic                              full,
  output logic                              empty,
  output logic [level_w(FIFO_DEPTH)-1:0]    level,
  output logic                              overflow
);

  localparam int BW = $clog2(DATA_WIDTH);

  tx_state_e             state_q, state_d;
  logic                  pop, done_d, bit_end, last_stop, can_start;
  logic [DATA_WIDTH-1:0] fifo_data, shift_q;
  logic [DIV_WIDTH-1:0]  timer_q, div_q;
  logic [BW-1:0]         bit_q;
  logic                  stop_q, par_en_q, par_bit_q, two_stop_q;
  parity_e               par_sel;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (din),
    .push     (wr_en),
    .pop      (pop),
    .rd_data  (fifo_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  assign can_start = tx_enable && !empty;
  assign bit_end   = (timer_q == div_q - 1'b1);
  assign last_stop = stop_q || !two_stop_q;
  assign par_sel   = decode_parity(parity_mode);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_done <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (can_start) begin
        pop     = 1'b1;
        state_d = START;
      end
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && bit_q == BW'(DATA_WIDTH-1)) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      // Ending the last stop bit can chain straight into the next start bit.
      STOP: if (bit_end && last_stop) begin
        done_d = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state_q != IDLE);
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      PARITY:  tx = par_bit_q;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
    end else if (pop) begin
      timer_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
    end else if (state_q != IDLE) begin
      if (bit_end) begin
        timer_q <= '0;
        if (state_q == DATA) bit_q  <= bit_q + 1'b1;
        if (state_q == STOP) stop_q <= 1'b1;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // Frame configuration is frozen at pop so mid-frame changes only hit later frames.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q    <= fifo_data;
      div_q      <= (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
      par_en_q   <= (par_sel != PAR_NONE);
      par_bit_q  <= (par_sel == PAR_ODD) ^ (^fifo_data);
      two_stop_q <= two_stop;
    end else if (state_q == DATA && bit_end) begin
      shift_q    <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of the buffered UART transmitter against a frame model.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        wr_en, tx_enable, two_stop;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        tx, tx_done, busy, full, empty, overflow;
  logic [4:0]  level;

  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .tx_enable(tx_enable),
    .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx(tx), .tx_done(tx_done), .busy(busy), .full(full), .empty(empty),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    din   = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Expected line: start, data LSB first, optional parity, stop bit(s); each bit lasts div cycles.
  task automatic check_frame(input string tag, input logic [7:0] data, input int div,
                             input logic [1:0] pm, input logic ts, input int exp_wait,
                             input int exp_lvl);
    logic         bits [16];
    int           nb, d, len, waited;
    logic [127:0] obs_tx, exp_tx, obs_dn, obs_bz, exp_bz;
    d = (div == 0) ? 1 : div;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    nb = 9;
    if (pm == 2'b01) begin bits[nb] = ^data;  nb++; end
    if (pm == 2'b10) begin bits[nb] = ~^data; nb++; end
    bits[nb] = 1'b1; nb++;
    if (ts) begin bits[nb] = 1'b1; nb++; end
    len = d * nb;
    waited = 0;
    while (tx !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      chk({tag, "_start_timeout"}, 128'(tx), 128'(0));
      return;
    end
    if (exp_wait >= 0) chk({tag, "_latency"}, 128'(waited), 128'(exp_wait));
    if (exp_lvl >= 0)  chk({tag, "_level"}, 128'(level), 128'(exp_lvl));
    obs_tx = '0; exp_tx = '0; obs_dn = '0; obs_bz = '0;
    for (int c = 0; c < len; c++) begin
      obs_tx[c] = tx;
      exp_tx[c] = bits[c / d];
      if (c > 0) obs_dn[c] = tx_done;
      obs_bz[c] = busy;
      @(negedge clk);
    end
    exp_bz = (128'(1) << len) - 128'(1);
    chk({tag, "_tx_wave"}, obs_tx, exp_tx);
    chk({tag, "_done_early"}, obs_dn, 128'(0));
    chk({tag, "_busy"}, obs_bz, exp_bz);
    chk({tag, "_done_end"}, 128'(tx_done), 128'(1));
  endtask

  initial begin
    rst = 1'b0; din = '0; wr_en = 1'b0; tx_enable = 1'b1;
    baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tx", 128'(tx), 128'(1));
    chk("rst_done", 128'(tx_done), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));

    // 8N1 at divisor 4, then even and odd parity
    do_write(8'hA5);
    check_frame("a5_none", 8'hA5, 4, 2'b00, 1'b0, 1, 0);
    chk("a5_busy_after", 128'(busy), 128'(0));
    parity_mode = 2'b01;
    do_write(8'hA5);
    check_frame("a5_even", 8'hA5, 4, 2'b01, 1'b0, 1, 0);
    parity_mode = 2'b10;
    do_write(8'hA5);
    check_frame("a5_odd", 8'hA5, 4, 2'b10, 1'b0, 1, 0);

    // Three queued words sent back to back, 24 cycles each
    tx_enable = 1'b0; baud_div = 16'd2; parity_mode = 2'b01; two_stop = 1'b1;
    din = 8'h01; wr_en = 1'b1; @(negedge clk);
    din = 8'h02; @(negedge clk);
    din = 8'h03; @(negedge clk);
    wr_en = 1'b0;
    chk("b2b_level3", 128'(level), 128'(3));
    tx_enable = 1'b1;
    check_frame("b2b_0", 8'h01, 2, 2'b01, 1'b1, 1, 2);
    check_frame("b2b_1", 8'h02, 2, 2'b01, 1'b1, 0, 1);
    check_frame("b2b_2", 8'h03, 2, 2'b01, 1'b1, 0, 0);
    chk("b2b_idle", 128'(busy), 128'(0));

    // Fill to full with the transmitter held, overflow on the 17th write
    tx_enable = 1'b0; baud_div = 16'd2; parity_mode = 2'b00; two_stop = 1'b0;
    q.delete();
    for (int i = 0; i < 17; i++) begin
      din = 8'($urandom);
      wr_en = 1'b1;
      if (i < 16) q.push_back(din);
      @(negedge clk);
      if (i == 15) begin
        chk("fill_full", 128'(full), 128'(1));
        chk("fill_level16", 128'(level), 128'(16));
        chk("fill_no_ovf", 128'(overflow), 128'(0));
      end
      if (i == 16) begin
        chk("fill_ovf_pulse", 128'(overflow), 128'(1));
        chk("fill_level_hold", 128'(level), 128'(16));
      end
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("fill_ovf_clear", 128'(overflow), 128'(0));
    tx_enable = 1'b1;
    for (int i = 0; i < 16; i++)
      check_frame($sformatf("drain_%0d", i), q[i], 2, 2'b00, 1'b0, (i == 0) ? 1 : 0, 15 - i);
    chk("drain_empty", 128'(empty), 128'(1));

    // Divisor 0 behaves as divisor 1
    baud_div = 16'd0;
    do_write(8'h3C);
    check_frame("div0", 8'h3C, 0, 2'b00, 1'b0, 1, 0);

    // Asynchronous reset in the middle of the data bits
    baud_div = 16'd4;
    do_write(8'h00);
    do_write(8'hFF);
    repeat (10) @(negedge clk);
    chk("mid_busy", 128'(busy), 128'(1));
    chk("mid_level", 128'(level), 128'(1));
    chk("mid_tx_low", 128'(tx), 128'(0));
    #2 rst = 1'b0;
    #1;
    chk("arst_tx", 128'(tx), 128'(1));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_level", 128'(level), 128'(0));
    chk("arst_empty", 128'(empty), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_write(8'h5A);
    check_frame("post_rst", 8'h5A, 4, 2'b00, 1'b0, 1, 0);

    // Randomized single frames with random configuration
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      int         dv;
      logic [1:0] pm;
      logic       ts;
      d  = 8'($urandom);
      dv = $urandom_range(0, 5);
      pm = 2'($urandom_range(0, 3));
      ts = 1'($urandom_range(0, 1));
      baud_div = 16'(dv); parity_mode = pm; two_stop = ts;
      do_write(d);
      check_frame($sformatf("rand_%0d", k), d, dv, pm, ts, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO, runtime baud divisor, selectable parity and 1/2 stop bits. Software/driver side pushes words into the FIFO. An internal frame FSM serialises them back-to-back onto tx, LSB first. Successor to the fixed 8N1 single-word transmitter; sits between the bus-side register block and the pad.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
FIFO_DEPTH, 16, FIFO entries; power of two, >=2.
DIV_WIDTH, 16, width of baud_div.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous, active-low reset.
din  input  DATA_WIDTH  write data.
wr_en  input  1  push din into FIFO this cycle.
tx_enable  input  1  1 = FSM may start new frames; 0 = finish current frame, then hold.
baud_div  input  DIV_WIDTH  clk cycles per bit; 0 treated as 1.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
two_stop  input  1  1 = two stop bits.
tx  output  1  serial line, idle high.
tx_done  output  1  one-cycle pulse at end of each frame.
busy  output  1  FSM not in IDLE.
full  output  1  FIFO count == FIFO_DEPTH.
empty  output  1  FIFO count == 0.
level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
overflow  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (rst low, async): tx=1, tx_done=0, busy=0, full=0, empty=1, level=0, overflow=0, FSM=IDLE, pointers/counters cleared. Takes effect mid-frame; the in-flight frame is abandoned.
- FIFO: write accepted when wr_en && !full. full is evaluated on current count, so a write while full is dropped even if a pop occurs the same cycle; overflow pulses next cycle. Pointers wrap modulo FIFO_DEPTH. Simultaneous push+pop with 0<count<DEPTH leaves level unchanged.
- No fall-through: a word written at edge N makes empty=0 after N. If FSM is IDLE and tx_enable=1, it pops at edge N+1, and tx drives the start bit from N+1.
- Config latch: baud_div (0->1), parity_mode and two_stop are captured at pop. Changes mid-frame do not affect the current frame.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP -> IDLE, or START directly.
- Bit timer counts 0..div-1; each bit lasts exactly div cycles.
- START: tx=0.
- DATA: DATA_WIDTH bits, LSB first.
- PARITY: even = XOR of data bits; odd = inverted XOR.
- STOP: tx=1 for 1 or 2 bit times.
- Frame length = div*(1+DATA_WIDTH+P+S) cycles; P is 0/1, S is 1/2.
- tx_done: asserted in the cycle after the last stop-bit cycle.
- Back-to-back: on that same edge, if the FIFO is non-empty and tx_enable=1, pop and enter START. No idle gap between frames.
- tx_enable=0: only prevents leaving IDLE. A frame in progress completes normally.
- busy: high from the pop edge through the last stop-bit cycle.

Decomposition:
- Package uart_pkg: parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD); tx_state_e enum (IDLE, START, DATA, PARITY, STOP); localparam helpers for level width.
- One natural sub-module: uart_sync_fifo (parametrised DATA_WIDTH/FIFO_DEPTH, push/pop, full/empty/level). The top holds the FSM, bit timer and shift register.

Test Plan:
- baud_div=4, 8 bits, no parity, 1 stop; write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulses 40 cycles after pop; busy drops with it.
- Same with parity_mode=01 then 10, data 0xA5 -> parity bit 0 (even), then 1 (odd); frame 44 cycles.
- Write 0x01,0x02,0x03 on consecutive cycles, baud_div=2, two_stop=1 -> tx_done pulses exactly 24 cycles apart; tx never returns to idle between frames beyond the stop bits; level 3->2->1->0.
- tx_enable=0; write 17 words -> full=1, level=16 after the 16th; 17th dropped with overflow pulse. Set tx_enable=1 -> 16 frames sent, empty=1.
- baud_div=0 with a single word -> treated as 1, frame length 10 cycles.
- Assert rst mid-DATA -> tx=1, busy=0, level=0 immediately (before next clk edge); after release, a new write produces a clean full frame.
